fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_pkg.sv | 11 +
 rtl/fifo_rd_ctrl_if.sv | 24 ++
 rtl/fifo_rd_ctrl_ptr_sync.sv | 23 ++
 rtl/fifo_rd_ctrl.sv | 58 +++++
 tb/tb_fifo_rd_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants and pointer helpers for the FIFO read-side controller.
package fifo_rd_ctrl_pkg;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_ADDRESS = 4;
  localparam int DEF_DEPTH   = 8;

  // Wide enough for any pointer width; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus between the FIFO memory/consumer and the read controller.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH   = fifo_rd_ctrl_pkg::DEF_WIDTH,
  parameter int ADDRESS = fifo_rd_ctrl_pkg::DEF_ADDRESS
);
  logic [ADDRESS-1:0] W_PTR_GRAY;
  logic [WIDTH-1:0]   MEM_RDATA;
  logic               R_READY;
  logic [ADDRESS-2:0] R_ADDR;
  logic [ADDRESS-1:0] R_PTR_GRAY;
  logic [WIDTH-1:0]   R_DATA;
  logic               R_VALID;
  logic               R_EMPTY;

  modport master (
    input  W_PTR_GRAY, MEM_RDATA, R_READY,
    output R_ADDR, R_PTR_GRAY, R_DATA, R_VALID, R_EMPTY
  );

  modport slave (
    output W_PTR_GRAY, MEM_RDATA, R_READY,
    input  R_ADDR, R_PTR_GRAY, R_DATA, R_VALID, R_EMPTY
  );
endinterface

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Multi-flop synchronizer carrying a Gray pointer into the local clock domain.
module ptr_sync #(
  parameter int BUS_WIDTH  = 4,
  parameter int NUM_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [BUS_WIDTH-1:0] q
);
  logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < NUM_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[NUM_STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: syncs the write pointer, fetches the
// head word from external memory into a registered valid/ready output stage.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDRESS = DEF_ADDRESS,
  parameter int DEPTH   = DEF_DEPTH
) (
  input logic           R_CLK,
  input logic           R_RST,
  fifo_rd_ctrl_if.master bus
);
  if (DEPTH != 2 ** (ADDRESS - 1)) begin : g_bad_depth
    $error("DEPTH must equal 2**(ADDRESS-1)");
  end

  logic [ADDRESS-1:0] wq2;
  logic [ADDRESS-1:0] rbin, rbin_next, rgray;
  logic [WIDTH-1:0]   rdata;
  logic               rvalid, empty, fetch;

  ptr_sync #(.BUS_WIDTH(ADDRESS), .NUM_STAGES(2)) u_wsync (
    .clk (R_CLK),
    .rst (R_RST),
    .d   (bus.W_PTR_GRAY),
    .q   (wq2)
  );

  // Output stage refills when empty or when its word is taken this cycle.
  assign empty     = (rgray == wq2);
  assign fetch     = !empty && (!rvalid || bus.R_READY);
  assign rbin_next = fetch ? rbin + ADDRESS'(1) : rbin;

  always_ff @(posedge R_CLK) begin
    if (!R_RST) begin
      rbin   <= '0;
      rgray  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rbin  <= rbin_next;
      rgray <= ADDRESS'(bin2gray(32'(rbin_next)));
      if (fetch) begin
        rdata  <= bus.MEM_RDATA;
        rvalid <= 1'b1;
      end else if (bus.R_READY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign bus.R_ADDR     = rbin[ADDRESS-2:0];
  assign bus.R_PTR_GRAY = rgray;
  assign bus.R_DATA     = rdata;
  assign bus.R_VALID    = rvalid;
  assign bus.R_EMPTY    = empty;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl against a word-count/queue reference model.
module tb_fifo_rd_ctrl;
  localparam int W = 8;
  localparam int A = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.WIDTH(W), .ADDRESS(A)) bus ();

  fifo_rd_ctrl #(.WIDTH(W), .ADDRESS(A), .DEPTH(D)) dut (
    .R_CLK (clk),
    .R_RST (rst),
    .bus   (bus)
  );

  // The FIFO memory lives in the bench; the DUT only addresses it.
  logic [W-1:0] mem [D];
  assign bus.MEM_RDATA = mem[bus.R_ADDR];

  int nvec = 0;
  int nerr = 0;

  // Reference model: words by write index, counts of written/fetched/consumed
  // words, and the written count as seen one and two edges ago.
  logic [W-1:0] words [4096];
  int wcount, rcount, cons, s1, s2;
  logic         mvalid;
  logic [W-1:0] mdata;

  function automatic logic [A-1:0] gray4(input int n);
    logic [A-1:0] b;
    b = A'(n % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    wcount = 0; rcount = 0; cons = 0; s1 = 0; s2 = 0;
    mvalid = 1'b0; mdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.R_READY = 1'b0;
    bus.W_PTR_GRAY = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  // One clock: apply ready/write, advance the model, then compare all outputs.
  task automatic step(input logic rdy, input logic wr, input logic [W-1:0] d);
    bit fetch_m;
    bus.R_READY = rdy;
    if (wr && (wcount - rcount) < D) begin
      mem[wcount % D] = d;
      words[wcount] = d;
      wcount++;
      bus.W_PTR_GRAY = gray4(wcount);
    end
    if (bus.R_VALID === 1'b1 && rdy) begin
      nvec++;
      if (bus.R_DATA !== words[cons]) begin
        nerr++;
        $display("FAIL consumed_word[%0d]: got %h want %h", cons, bus.R_DATA, words[cons]);
      end
      cons++;
    end
    fetch_m = (s2 != rcount) && (!mvalid || rdy);
    if (fetch_m) begin
      mdata = words[rcount];
      rcount++;
      mvalid = 1'b1;
    end else if (rdy) begin
      mvalid = 1'b0;
    end
    s2 = s1;
    s1 = wcount;
    @(posedge clk); #1;
    nvec++;
    if (bus.R_VALID !== mvalid || bus.R_DATA !== mdata) begin
      nerr++;
      $display("FAIL valid_data t=%0t: got %b/%h want %b/%h", $time, bus.R_VALID, bus.R_DATA, mvalid, mdata);
    end
    nvec++;
    if (bus.R_EMPTY !== (s2 == rcount)) begin
      nerr++;
      $display("FAIL empty t=%0t: got %b want %b", $time, bus.R_EMPTY, (s2 == rcount));
    end
    nvec++;
    if (bus.R_ADDR !== 3'(rcount % D) || bus.R_PTR_GRAY !== gray4(rcount)) begin
      nerr++;
      $display("FAIL pointers t=%0t: got addr %0d gray %b want addr %0d gray %b", $time,
               bus.R_ADDR, bus.R_PTR_GRAY, rcount % D, gray4(rcount));
    end
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (bus.R_VALID !== 1'b0 || bus.R_EMPTY !== 1'b1 || bus.R_ADDR !== 3'd0 ||
        bus.R_PTR_GRAY !== 4'b0000 || bus.R_DATA !== 8'h00) begin
      nerr++;
      $display("FAIL reset_state: got v=%b e=%b a=%0d g=%b d=%h want 0 1 0 0000 00",
               bus.R_VALID, bus.R_EMPTY, bus.R_ADDR, bus.R_PTR_GRAY, bus.R_DATA);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b0, 1'b1, 8'hA5);
    nvec++;
    if (bus.R_EMPTY !== 1'b1 || bus.R_VALID !== 1'b0) begin
      nerr++;
      $display("FAIL single_edge1: got e=%b v=%b want 1 0", bus.R_EMPTY, bus.R_VALID);
    end
    step(1'b0, 1'b0, 8'h00);
    nvec++;
    if (bus.R_EMPTY !== 1'b0 || bus.R_VALID !== 1'b0) begin
      nerr++;
      $display("FAIL single_edge2: got e=%b v=%b want 0 0", bus.R_EMPTY, bus.R_VALID);
    end
    step(1'b0, 1'b0, 8'h00);
    nvec++;
    if (bus.R_VALID !== 1'b1 || bus.R_DATA !== 8'hA5 || bus.R_ADDR !== 3'd1 || bus.R_EMPTY !== 1'b1) begin
      nerr++;
      $display("FAIL single_edge3: got v=%b d=%h a=%0d e=%b want 1 a5 1 1",
               bus.R_VALID, bus.R_DATA, bus.R_ADDR, bus.R_EMPTY);
    end
  endtask

  task automatic test_stream();
    int run = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i < 8, 8'(i + 1));
      if (bus.R_VALID === 1'b1) run++;
    end
    nvec++;
    if (run !== 8 || cons !== 8 || bus.R_PTR_GRAY !== 4'b1100) begin
      nerr++;
      $display("FAIL stream: got run=%0d cons=%0d gray=%b want 8 8 1100", run, cons, bus.R_PTR_GRAY);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    nvec++;
    if (bus.R_DATA !== 8'h11 || bus.R_ADDR !== 3'd1 || bus.R_VALID !== 1'b1) begin
      nerr++;
      $display("FAIL backpressure_hold: got d=%h a=%0d v=%b want 11 1 1", bus.R_DATA, bus.R_ADDR, bus.R_VALID);
    end
    step(1'b1, 1'b0, 8'h00);
    nvec++;
    if (bus.R_DATA !== 8'h22) begin
      nerr++;
      $display("FAIL backpressure_w2: got %h want 22", bus.R_DATA);
    end
    step(1'b1, 1'b0, 8'h00);
    nvec++;
    if (bus.R_DATA !== 8'h33) begin
      nerr++;
      $display("FAIL backpressure_w3: got %h want 33", bus.R_DATA);
    end
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    bit saw7 = 0, saw70 = 0, saw701 = 0;
    logic [2:0] prev;
    do_reset();
    prev = bus.R_ADDR;
    for (int i = 0; i < 300 && !(wcount == 20 && cons == 20); i++) begin
      step(1'($urandom_range(0, 3) != 0), wcount < 20, 8'($urandom));
      if (bus.R_ADDR != prev) begin
        if (saw70 && bus.R_ADDR == 3'd1) saw701 = 1;
        saw70 = saw7 && bus.R_ADDR == 3'd0;
        saw7  = bus.R_ADDR == 3'd7;
        prev  = bus.R_ADDR;
      end
    end
    nvec++;
    if (cons !== 20 || bus.R_PTR_GRAY !== 4'b0110 || !saw701) begin
      nerr++;
      $display("FAIL wrap: got cons=%0d gray=%b seq701=%0d want 20 0110 1", cons, bus.R_PTR_GRAY, saw701);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
    nvec++;
    if (bus.R_VALID !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid_pre: got v=%b want 1", bus.R_VALID);
    end
    do_reset();
    nvec++;
    if (bus.R_VALID !== 1'b0 || bus.R_DATA !== 8'h00 || bus.R_ADDR !== 3'd0 ||
        bus.R_PTR_GRAY !== 4'b0000 || bus.R_EMPTY !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid: got v=%b d=%h a=%0d g=%b e=%b want 0 00 0 0000 1",
               bus.R_VALID, bus.R_DATA, bus.R_ADDR, bus.R_PTR_GRAY, bus.R_EMPTY);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom), 1'($urandom_range(0, 2) != 0), 8'($urandom));
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00);
    nvec++;
    if (cons !== wcount) begin
      nerr++;
      $display("FAIL random_drain: got consumed=%0d want %0d", cons, wcount);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = '0;
    bus.R_READY = 1'b0;
    bus.W_PTR_GRAY = '0;
    model_clear();
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
